// File: rtl/reg_port_initiator.sv
// Operand-fetch initiator: reads up to two register-file sources per request and presents them on a hold handshake.
// Optional macro WB_FORWARD_EN forwards a same-cycle writeback instead of stalling the read for one cycle.
module reg_port_initiator #(
    parameter int DATA_W = 18,
    parameter int ADDR_W = 4
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              ReqValid,
    output logic              ReqReady,
    input  logic [ADDR_W-1:0] ReqSrc1,
    input  logic [ADDR_W-1:0] ReqSrc2,
    input  logic              ReqUseSrc2,
    input  logic              WbValid,
    input  logic [ADDR_W-1:0] WbRegister,
    input  logic [DATA_W-1:0] WbData,
    output logic              OpValid,
    input  logic              OpReady,
    output logic [DATA_W-1:0] Operand1,
    output logic [DATA_W-1:0] Operand2,
    output logic              ReadEnable1,
    output logic              ReadEnable2,
    output logic [ADDR_W-1:0] ReadRegister1,
    output logic [ADDR_W-1:0] ReadRegister2,
    input  logic [DATA_W-1:0] ReadData1,
    input  logic [DATA_W-1:0] ReadData2,
    output logic              RegWrite,
    output logic [ADDR_W-1:0] WriteRegister,
    output logic [DATA_W-1:0] WriteData
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        READ = 2'd1,
        HOLD = 2'd2
    } state_t;

    state_t state;
    logic   use_src2;
    logic   hit1;
    logic   hit2;

    // Writeback goes straight to the register file, reset or not.
    assign RegWrite      = WbValid;
    assign WriteRegister = WbRegister;
    assign WriteData     = WbData;

    // A writeback only conflicts with a source the read port is actually using.
    assign hit1 = (state == READ) && WbValid && (WbRegister == ReadRegister1);
    assign hit2 = (state == READ) && WbValid && use_src2 && (WbRegister == ReadRegister2);

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state         <= IDLE;
            ReqReady      <= 1'b1;
            OpValid       <= 1'b0;
            ReadEnable1   <= 1'b0;
            ReadEnable2   <= 1'b0;
            ReadRegister1 <= '0;
            ReadRegister2 <= '0;
            use_src2      <= 1'b0;
            Operand1      <= '0;
            Operand2      <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (ReqValid) begin
                        ReadRegister1 <= ReqSrc1;
                        ReadRegister2 <= ReqSrc2;
                        use_src2      <= ReqUseSrc2;
                        ReadEnable1   <= 1'b1;
                        ReadEnable2   <= ReqUseSrc2;
                        ReqReady      <= 1'b0;
                        state         <= READ;
                    end
                end
                READ: begin
`ifdef WB_FORWARD_EN
                    Operand1    <= hit1 ? WbData : ReadData1;
                    Operand2    <= use_src2 ? (hit2 ? WbData : ReadData2) : '0;
                    ReadEnable1 <= 1'b0;
                    ReadEnable2 <= 1'b0;
                    OpValid     <= 1'b1;
                    state       <= HOLD;
`else
                    // Stay put until the conflicting write has landed in the register file.
                    if (!(hit1 || hit2)) begin
                        Operand1    <= ReadData1;
                        Operand2    <= use_src2 ? ReadData2 : '0;
                        ReadEnable1 <= 1'b0;
                        ReadEnable2 <= 1'b0;
                        OpValid     <= 1'b1;
                        state       <= HOLD;
                    end
`endif
                end
                HOLD: begin
                    if (OpReady) begin
                        OpValid  <= 1'b0;
                        ReqReady <= 1'b1;
                        state    <= IDLE;
                    end
                end
                default: begin
                    OpValid     <= 1'b0;
                    ReqReady    <= 1'b1;
                    ReadEnable1 <= 1'b0;
                    ReadEnable2 <= 1'b0;
                    state       <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_reg_port_initiator.sv
// Directed bench for reg_port_initiator with a behavioural register file and an operand scoreboard.
module tb_reg_port_initiator;

    localparam int DW = 18;
    localparam int AW = 4;
`ifdef WB_FORWARD_EN
    localparam int CONFLICT_LAT = 2;
`else
    localparam int CONFLICT_LAT = 3;
`endif

    logic          Clk;
    logic          Reset;
    logic          ReqValid;
    logic          ReqReady;
    logic [AW-1:0] ReqSrc1;
    logic [AW-1:0] ReqSrc2;
    logic          ReqUseSrc2;
    logic          WbValid;
    logic [AW-1:0] WbRegister;
    logic [DW-1:0] WbData;
    logic          OpValid;
    logic          OpReady;
    logic [DW-1:0] Operand1;
    logic [DW-1:0] Operand2;
    logic          ReadEnable1;
    logic          ReadEnable2;
    logic [AW-1:0] ReadRegister1;
    logic [AW-1:0] ReadRegister2;
    logic [DW-1:0] ReadData1;
    logic [DW-1:0] ReadData2;
    logic          RegWrite;
    logic [AW-1:0] WriteRegister;
    logic [DW-1:0] WriteData;

    reg_port_initiator #(.DATA_W(DW), .ADDR_W(AW)) dut (
        .Clk(Clk), .Reset(Reset),
        .ReqValid(ReqValid), .ReqReady(ReqReady),
        .ReqSrc1(ReqSrc1), .ReqSrc2(ReqSrc2), .ReqUseSrc2(ReqUseSrc2),
        .WbValid(WbValid), .WbRegister(WbRegister), .WbData(WbData),
        .OpValid(OpValid), .OpReady(OpReady),
        .Operand1(Operand1), .Operand2(Operand2),
        .ReadEnable1(ReadEnable1), .ReadEnable2(ReadEnable2),
        .ReadRegister1(ReadRegister1), .ReadRegister2(ReadRegister2),
        .ReadData1(ReadData1), .ReadData2(ReadData2),
        .RegWrite(RegWrite), .WriteRegister(WriteRegister), .WriteData(WriteData)
    );

    // Register file the initiator drives.
    logic [DW-1:0] rf [16];
    always @(posedge Clk) if (RegWrite) rf[WriteRegister] <= WriteData;
    assign ReadData1 = rf[ReadRegister1];
    assign ReadData2 = rf[ReadRegister2];

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    typedef struct {
        logic [DW-1:0] op1;
        logic [DW-1:0] op2;
    } exp_t;
    exp_t sb[$];

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic wb(input logic [AW-1:0] r, input logic [DW-1:0] d);
        WbValid = 1'b1; WbRegister = r; WbData = d;
        @(posedge Clk); #1;
        WbValid = 1'b0;
    endtask

    task automatic push(input logic [DW-1:0] o1, input logic [DW-1:0] o2);
        exp_t e;
        e.op1 = o1; e.op2 = o2;
        sb.push_back(e);
    endtask

    // Issue one request, optionally write back during its READ cycle, optionally
    // stall OpReady for `hold` cycles while writing R5, then complete the handshake.
    task automatic do_req(input string tag, input logic [AW-1:0] s1, input logic [AW-1:0] s2,
                          input logic u2, input int exp_lat, input logic wbv,
                          input logic [AW-1:0] wbr, input logic [DW-1:0] wbd, input int hold);
        int   lat;
        exp_t e;
        ReqSrc1 = s1; ReqSrc2 = s2; ReqUseSrc2 = u2; ReqValid = 1'b1;
        check({tag, ".req_ready"}, ReqReady, 1);
        @(posedge Clk); #1;
        ReqValid = 1'b0;
        lat = 1;
        check({tag, ".rd_en1"}, ReadEnable1, 1);
        check({tag, ".rd_en2"}, ReadEnable2, u2);
        if (wbv) begin
            WbValid = 1'b1; WbRegister = wbr; WbData = wbd;
        end
        while (!OpValid && lat < 8) begin
            @(posedge Clk); #1;
            WbValid = 1'b0;
            lat++;
        end
        check({tag, ".latency"}, lat, exp_lat);
        n_cmp++;
        assert (sb.size() > 0) else begin
            n_fail++;
            $error("FAIL %s.sb observed=empty expected=entry", tag);
        end
        if (sb.size() > 0) begin
            e = sb.pop_front();
            check({tag, ".op1"}, Operand1, e.op1);
            check({tag, ".op2"}, Operand2, e.op2);
            for (int i = 0; i < hold; i++) begin
                WbValid = 1'b1; WbRegister = 4'd5; WbData = 18'd999;
                @(posedge Clk); #1;
                check({tag, ".hold_op1"}, Operand1, e.op1);
                check({tag, ".hold_vld"}, OpValid, 1);
                check({tag, ".hold_rdy"}, ReqReady, 0);
            end
            WbValid = 1'b0;
        end
        OpReady = 1'b1;
        @(posedge Clk); #1;
        OpReady = 1'b0;
        check({tag, ".vld_drop"}, OpValid, 0);
        check({tag, ".rdy_back"}, ReqReady, 1);
        check({tag, ".rd_en_off"}, ReadEnable1, 0);
    endtask

    initial begin
        Reset = 1'b1; ReqValid = 1'b0; ReqSrc1 = '0; ReqSrc2 = '0; ReqUseSrc2 = 1'b0;
        WbValid = 1'b0; WbRegister = '0; WbData = '0; OpReady = 1'b0;
        #2;
        check("rst.op_valid", OpValid, 0);
        check("rst.req_ready", ReqReady, 1);
        check("rst.rd_en1", ReadEnable1, 0);
        check("rst.rd_en2", ReadEnable2, 0);
        check("rst.op1", Operand1, 0);
        check("rst.op2", Operand2, 0);
        check("rst.rd_reg1", ReadRegister1, 0);
        WbValid = 1'b1; WbRegister = 4'd0; WbData = 18'd0;
        #1;
        check("rst.reg_write", RegWrite, 1);
        WbValid = 1'b0;
        #1;
        check("rst.reg_write_off", RegWrite, 0);
        @(posedge Clk); #1;
        Reset = 1'b0;
        @(posedge Clk); #1;

        // Simple single-source read.
        wb(4'd5, 18'd123);
        @(posedge Clk); #1;
        push(18'd123, 18'd0);
        do_req("r5", 4'd5, 4'd0, 1'b0, 2, 1'b0, 4'd0, 18'd0, 0);

        // Two sources, max data value.
        wb(4'd3, 18'd7);
        wb(4'd9, 18'h3FFFF);
        push(18'd7, 18'h3FFFF);
        do_req("r3r9", 4'd3, 4'd9, 1'b1, 2, 1'b0, 4'd0, 18'd0, 0);

        // Writeback to source 1 during READ.
        push(18'd456, 18'd0);
        do_req("conf1", 4'd5, 4'd0, 1'b0, CONFLICT_LAT, 1'b1, 4'd5, 18'd456, 0);

        // Same register on both sources.
        push(18'h3FFFF, 18'h3FFFF);
        do_req("same", 4'd9, 4'd9, 1'b1, 2, 1'b0, 4'd0, 18'd0, 0);

        // Writeback to source 2 during READ.
        push(18'h3FFFF, 18'd55);
        do_req("conf2", 4'd9, 4'd3, 1'b1, CONFLICT_LAT, 1'b1, 4'd3, 18'd55, 0);

        // Write to an unused source-2 index is not a conflict.
        push(18'h3FFFF, 18'd0);
        do_req("noconf", 4'd9, 4'd7, 1'b0, 2, 1'b1, 4'd7, 18'd11, 0);

        // Long HOLD with writes to the held register.
        push(18'd456, 18'd0);
        do_req("hold", 4'd5, 4'd0, 1'b0, 2, 1'b0, 4'd0, 18'd0, 10);
        push(18'd999, 18'd11);
        do_req("after_hold", 4'd5, 4'd7, 1'b1, 2, 1'b0, 4'd0, 18'd0, 0);

        // Asynchronous reset in the middle of READ.
        ReqSrc1 = 4'd3; ReqUseSrc2 = 1'b1; ReqSrc2 = 4'd9; ReqValid = 1'b1;
        @(posedge Clk); #1;
        ReqValid = 1'b0;
        check("arst.pre_rd_en1", ReadEnable1, 1);
        #2;
        Reset = 1'b1;
        WbValid = 1'b1; WbRegister = 4'd12; WbData = 18'd77;
        #1;
        check("arst.op_valid", OpValid, 0);
        check("arst.rd_en1", ReadEnable1, 0);
        check("arst.rd_en2", ReadEnable2, 0);
        check("arst.op1", Operand1, 0);
        check("arst.op2", Operand2, 0);
        check("arst.req_ready", ReqReady, 1);
        check("arst.reg_write", RegWrite, 1);
        check("arst.wr_reg", WriteRegister, 12);
        @(posedge Clk); #1;
        WbValid = 1'b0;
        Reset = 1'b0;
        @(posedge Clk); #1;
        check("arst.idle_vld", OpValid, 0);
        push(18'd999, 18'd77);
        do_req("post_rst", 4'd5, 4'd12, 1'b1, 2, 1'b0, 4'd0, 18'd0, 0);

        check("sb.drained", sb.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/reg_port_initiator.md
REG_PORT_INITIATOR -- requirements
Module: reg_port_initiator

Interface
REQ-001 Parameter DATA_W, default 18, SHALL set the register data width.
REQ-002 Parameter ADDR_W, default 4, SHALL set the register index width (16 registers).
REQ-003 The block SHALL use one clock and an asynchronous, active-high reset.
REQ-004 Clk  in  1  rising-edge clock for all state.
REQ-005 Reset  in  1  asynchronous active-high reset.
REQ-006 ReqValid  in  1  operand-fetch request valid.
REQ-007 ReqReady  out  1  request accepted when ReqValid&&ReqReady at a Clk edge.
REQ-008 ReqSrc1, ReqSrc2  in  ADDR_W each  source register indices.
REQ-009 ReqUseSrc2  in  1  second operand needed.
REQ-010 WbValid  in  1  writeback strobe; always accepted, no ready.
REQ-011 WbRegister  in  ADDR_W  and WbData  in  DATA_W  writeback target and value.
REQ-012 OpValid  out  1; OpReady  in  1  operand output handshake.
REQ-013 Operand1, Operand2  out  DATA_W  fetched operands.
REQ-014 ReadEnable1, ReadEnable2  out  1; ReadRegister1, ReadRegister2  out  ADDR_W  register-file read port drive.
REQ-015 ReadData1, ReadData2  in  DATA_W  register-file read data, valid in the same cycle as enable/index.
REQ-016 RegWrite  out  1; WriteRegister  out  ADDR_W; WriteData  out  DATA_W  register-file write port drive.

Function
REQ-017 RegWrite, WriteRegister, WriteData SHALL equal WbValid, WbRegister, WbData combinationally; the register file commits the write at the next Clk edge.
REQ-018 FSM states SHALL be IDLE, READ, HOLD.
REQ-019 IDLE: ReqReady=1; on accepted request, latch ReqSrc1/ReqSrc2/ReqUseSrc2 and go to READ.
REQ-020 READ: ReqReady=0; ReadEnable1=1; ReadEnable2=latched UseSrc2; ReadRegister1/2 = latched indices; ReadEnable signals SHALL be 0 in every other state.
REQ-021 A conflict SHALL exist in READ when WbValid=1 and WbRegister equals an enabled latched source index.
REQ-022 On leaving READ, Operand1 SHALL capture ReadData1 (or forwarded value per REQ-030), Operand2 SHALL capture ReadData2 if UseSrc2 else 0; next state HOLD.
REQ-023 HOLD: OpValid=1, operands stable; on OpReady=1 go to IDLE; OpValid SHALL deassert the cycle after the handshake.
REQ-024 Request-accept to OpValid latency SHALL be 2 Clk edges absent stalls; throughput one request per 3 cycles minimum.
REQ-025 While in HOLD with OpReady=0, the block SHALL hold indefinitely; WbValid writes SHALL still pass through and SHALL NOT alter held operands.
REQ-026 Both sources naming the same register SHALL return the same value in both operands.

Reset
REQ-027 Reset SHALL force IDLE immediately, independent of Clk, including mid-READ or mid-HOLD; the in-flight request is dropped.
REQ-028 During/after reset: OpValid=0, ReqReady=1 once in IDLE, Operand1=Operand2=0, latched indices=0, ReadEnable1=ReadEnable2=0.
REQ-029 RegWrite SHALL follow WbValid even during reset (pass-through, REQ-017).

Configuration
REQ-030 With WB_FORWARD_EN defined: on conflict in READ, the affected operand SHALL capture WbData instead of ReadDataN, no stall.
REQ-031 Without WB_FORWARD_EN: on conflict, the block SHALL remain in READ one further cycle (repeat while conflicts persist) and capture ReadDataN once no conflict exists.

Verification
REQ-032 Wb R5=123, idle; then request Src1=5, UseSrc2=0 -> OpValid after 2 edges, Operand1=123, Operand2=0.
REQ-033 R3=7, R9=0x3FFFF preloaded; request Src1=3, Src2=9, UseSrc2=1 -> Operand1=7, Operand2=0x3FFFF.
REQ-034 Request Src1=5 with WbValid, WbRegister=5, WbData=456 in READ cycle -> FORWARD_EN: Operand1=456, latency 2; without: one stall cycle, Operand1=456, latency 3.
REQ-035 OpReady held 0 for 10 cycles in HOLD while writing R5=999 -> Operand1 unchanged, OpValid stays 1, ReqReady=0.
REQ-036 Assert Reset mid-READ between edges -> same instant OpValid=0, ReadEnable1=0, operands 0; next request completes normally.
